// File: rtl/bk_pkg.sv
// Shared widths, result-entry type and operand interleave helper for the
// Brent-Kung adder stage.
package bk_pkg;

  localparam int OP_W  = 12;
  localparam int BUS_W = 24;
  localparam int SUM_W = 13;

  typedef struct packed {
    logic            cout;
    logic [OP_W-1:0] sum;
  } res_t;

  // The adder expects bit 2i = A[i], bit 2i+1 = B[i].
  function automatic logic [BUS_W-1:0] interleave(input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
    logic [BUS_W-1:0] bus;
    bus = '0;
    for (int i = 0; i < OP_W; i++) begin
      bus[2*i]   = a[i];
      bus[2*i+1] = b[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/bk_add_fifo.sv
// Synchronous result FIFO for bk_add_stage; DEPTH must be a power of two so
// the pointers wrap naturally.
module bk_add_fifo
  import bk_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  res_t wr_data,
  output res_t rd_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  res_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Gate the read port so the head reads 0 while empty or in reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bk_add_stage.sv
// Operand/result staging around an external Brent-Kung adder.
// Define BK_ADD_STAGE_ACC_EN to add the in_acc port and the accumulator.
module bk_add_stage
  import bk_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
`ifdef BK_ADD_STAGE_ACC_EN
  input  logic             in_acc,
`endif
  output logic [BUS_W-1:0] add_bus,
  input  logic [SUM_W-1:0] sum_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_sum,
  output logic             out_cout
);

  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic [OP_W-1:0] b_sel;
  logic            op_vld;
  logic            load;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  res_t            wr_entry;
  res_t            rd_entry;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = op_vld && (!full || pop);
  assign in_ready  = !op_vld || !full || pop;
  assign load      = in_valid && in_ready;

  // A fresh load on the same edge as the push keeps op_vld set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
    end else if (load) begin
      op_vld <= 1'b1;
      op_a   <= in_a;
      op_b   <= in_b;
    end else if (push) begin
      op_vld <= 1'b0;
    end
  end

`ifdef BK_ADD_STAGE_ACC_EN
  logic            op_acc;
  logic [OP_W-1:0] acc;

  // acc updates on the same edge a following operand is captured, so
  // back-to-back accumulation needs no bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_acc <= 1'b0;
      acc    <= '0;
    end else begin
      if (load) op_acc <= in_acc;
      if (push) acc    <= sum_bus[OP_W-1:0];
    end
  end

  assign b_sel = op_acc ? acc : op_b;
`else
  assign b_sel = op_b;
`endif

  assign add_bus  = op_vld ? interleave(op_a, b_sel) : '0;
  assign wr_entry = '{cout: sum_bus[OP_W], sum: sum_bus[OP_W-1:0]};

  bk_add_fifo #(
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wr_data(wr_entry),
    .rd_data(rd_entry),
    .full   (full),
    .empty  (empty)
  );

  assign out_sum  = rd_entry.sum;
  assign out_cout = rd_entry.cout;

endmodule

// File: tb/tb_bk_add_stage.sv
// Directed and random checks of bk_add_stage against a behavioural adder.
module tb_bk_add_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        in_acc;
  logic [23:0] add_bus;
  logic [12:0] sum_bus;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_cout;

  int n_cmp = 0;
  int n_err = 0;

  bk_add_stage #(
    .OUT_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
`ifdef BK_ADD_STAGE_ACC_EN
    .in_acc   (in_acc),
`endif
    .add_bus  (add_bus),
    .sum_bus  (sum_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder: de-interleave the bus and add.
  logic [11:0] mdl_a;
  logic [11:0] mdl_b;
  always_comb begin
    mdl_a = '0;
    mdl_b = '0;
    for (int i = 0; i < 12; i++) begin
      mdl_a[i] = add_bus[2*i];
      mdl_b[i] = add_bus[2*i+1];
    end
  end
  assign sum_bus = {1'b0, mdl_a} + {1'b0, mdl_b};

  function automatic logic [23:0] tb_ilv(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] r;
    for (int i = 0; i < 12; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_acc = 1'b0;
    in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (add_bus !== 24'h0) begin n_err++; $display("[TB] FAIL rst_add_bus: got %h want 000000", add_bus); end
    n_cmp++; if ({out_cout, out_sum} !== 13'h0) begin n_err++; $display("[TB] FAIL rst_out: got %h want 0000", {out_cout, out_sum}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_interleave;
    @(negedge clk);
    in_a = 12'hAAA; in_b = 12'h555; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (add_bus !== 24'h666666) begin n_err++; $display("[TB] FAIL ilv_bus: got %h want 666666", add_bus); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL ilv_valid: got %b want 1", out_valid); end
    n_cmp++; if ({out_cout, out_sum} !== 13'h0FFF) begin n_err++; $display("[TB] FAIL ilv_result: got %h want 0fff", {out_cout, out_sum}); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL ilv_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_carry_latency;
    @(negedge clk);
    in_a = 12'hFFF; in_b = 12'h001; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL carry_early: got %b want 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL carry_valid: got %b want 1", out_valid); end
    n_cmp++; if ({out_cout, out_sum} !== 13'h1000) begin n_err++; $display("[TB] FAIL carry_result: got %h want 1000", {out_cout, out_sum}); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [11:0] pa [5];
    logic [11:0] pb [5];
    logic [12:0] exp_r [5];
    pa = '{12'h100, 12'h7FF, 12'hABC, 12'hF00, 12'h001};
    pb = '{12'h023, 12'h001, 12'h111, 12'h200, 12'h002};
    exp_r = '{13'h0123, 13'h0800, 13'h0BCD, 13'h1100, 13'h0003};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_a = pa[k]; in_b = pb[k]; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_accept%0d: got %b want 1", k, in_ready); end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_a = pa[3]; in_b = pb[3];
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_stall%0d: got %b want 0", k, in_ready); end
      n_cmp++; if (add_bus !== tb_ilv(pa[2], pb[2])) begin n_err++; $display("[TB] FAIL bp_bus_hold%0d: got %h want %h", k, add_bus, tb_ilv(pa[2], pb[2])); end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (k < 2) begin
        in_a = pa[k+3]; in_b = pb[k+3]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_drain_valid%0d: got %b want 1", k, out_valid); end
      n_cmp++; if ({out_cout, out_sum} !== exp_r[k]) begin n_err++; $display("[TB] FAIL bp_order%0d: got %h want %h", k, {out_cout, out_sum}, exp_r[k]); end
      if (k < 2) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_resume%0d: got %b want 1", k, in_ready); end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midflight;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_a = 12'h010 * 12'(k + 1); in_b = 12'h001; in_valid = 1'b1; out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL mid_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL mid_rst_ready: got %b want 1", in_ready); end
    n_cmp++; if (add_bus !== 24'h0) begin n_err++; $display("[TB] FAIL mid_rst_bus: got %h want 000000", add_bus); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_stale%0d: got %b want 0", k, out_valid); end
    end
    in_a = 12'h010; in_b = 12'h020; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_post_early: got %b want 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL mid_post_valid: got %b want 1", out_valid); end
    n_cmp++; if ({out_cout, out_sum} !== 13'h0030) begin n_err++; $display("[TB] FAIL mid_post_result: got %h want 0030", {out_cout, out_sum}); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef BK_ADD_STAGE_ACC_EN
  task automatic test_accumulate;
    @(negedge clk);
    out_ready = 1'b1;
    in_a = 12'd5; in_b = 12'd0; in_acc = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_a = 12'd3; in_b = 12'hFFF; in_acc = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL acc_ready1: got %b want 1", in_ready); end
    @(negedge clk);
    in_a = 12'd3; in_b = 12'h7A5; in_acc = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL acc_ready2: got %b want 1", in_ready); end
    n_cmp++; if ({out_valid, out_sum} !== {1'b1, 12'd5}) begin n_err++; $display("[TB] FAIL acc_out0: got %h want 1005", {out_valid, out_sum}); end
    @(negedge clk);
    in_valid = 1'b0; in_acc = 1'b0;
    #1;
    n_cmp++; if ({out_valid, out_sum} !== {1'b1, 12'd8}) begin n_err++; $display("[TB] FAIL acc_out1: got %h want 1008", {out_valid, out_sum}); end
    @(negedge clk);
    #1;
    n_cmp++; if ({out_valid, out_sum} !== {1'b1, 12'd11}) begin n_err++; $display("[TB] FAIL acc_out2: got %h want 100b", {out_valid, out_sum}); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask
`endif

  task automatic test_random;
    logic [12:0] q [$];
    logic [12:0] exp_v;
    int accepted = 0;
    int cycles = 0;
    bit taken = 1'b0;
    in_valid = 1'b0;
    while ((accepted < 10000 || q.size() != 0) && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      if (taken) in_valid = 1'b0;
      taken = 1'b0;
      if (!in_valid && accepted < 10000 && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_a = 12'($urandom);
        in_b = 12'($urandom);
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("[TB] FAIL rnd_extra: got %h want none", {out_cout, out_sum});
        end else begin
          exp_v = q.pop_front();
          if ({out_cout, out_sum} !== exp_v) begin n_err++; $display("[TB] FAIL rnd_result: got %h want %h", {out_cout, out_sum}, exp_v); end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({1'b0, in_a} + {1'b0, in_b});
        accepted++;
        taken = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (cycles >= 60000) begin n_err++; $display("[TB] FAIL rnd_timeout: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_interleave();
    test_carry_latency();
    test_backpressure();
    test_reset_midflight();
`ifdef BK_ADD_STAGE_ACC_EN
    test_accumulate();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
